// File: rtl/mmr_pkg.sv
// Shared definitions for the memory-mapped register bank: handshake FSM
// states, response error codes and the position of the optional lock bit.
package mmr_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE = 2'd0,
      ERR_OOR  = 2'd1,
      ERR_LOCK = 2'd2
   } err_e;

   localparam int LOCK_BIT = 0;

endpackage

// File: rtl/mmr_byte_reg.sv
// One register of the bank: byte-strobed bus write plus a full-word hardware
// load. When both hit on the same edge, strobed bytes take bus data and the
// remaining bytes take the hardware word.
module mmr_byte_reg #(
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                bus_we,
   input  logic [DATA_W/8-1:0] bus_wstrb,
   input  logic [DATA_W-1:0]   bus_wdata,
   input  logic                hw_we,
   input  logic [DATA_W-1:0]   hw_wdata,
   output logic [DATA_W-1:0]   q
);

   // Per-byte update with bus priority over the hardware load
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else begin
         for (int b = 0; b < DATA_W/8; b++) begin
            if (bus_we && bus_wstrb[b]) begin
               q[b*8 +: 8] <= bus_wdata[b*8 +: 8];
            end else if (hw_we) begin
               q[b*8 +: 8] <= hw_wdata[b*8 +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/mmr_bank.sv
// Memory-mapped register bank with a valid/ready request channel and a
// valid/ready response channel (one transaction per two cycles), per-register
// hardware load ports and per-register write strobes.
// Optional feature: define MMR_BANK_LOCK_EN to make bit 0 of the last
// register a sticky lock that blocks bus writes to all other registers.
module mmr_bank
   import mmr_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_write,
   input  logic [7:0]                 req_addr,
   input  logic [DATA_W-1:0]          req_wdata,
   input  logic [DATA_W/8-1:0]        req_wstrb,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [DATA_W-1:0]          rsp_rdata,
   output logic                       rsp_err,
   input  logic [NUM_REGS-1:0]        hw_we,
   input  logic [NUM_REGS*DATA_W-1:0] hw_wdata,
   output logic [NUM_REGS*DATA_W-1:0] reg_q,
   output logic [NUM_REGS-1:0]        wr_pulse
);

   localparam int ADDR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   state_e              state_q;
   state_e              state_d;
   logic [ADDR_W-1:0]   addr_idx;
   logic                addr_in_range;
   logic                accept;
   logic                lock_q;
   err_e                err_code;
   logic [NUM_REGS-1:0] bus_we;
   logic [DATA_W-1:0]   rd_word;
   logic [DATA_W-1:0]   reg_raw [NUM_REGS];
   logic [DATA_W-1:0]   reg_word [NUM_REGS];

   assign addr_idx      = req_addr[ADDR_W-1:0];
   assign addr_in_range = (req_addr < 8'(NUM_REGS));
   assign accept        = req_valid & req_ready;

   // Classify the presented request: out of range first, then lock violation
   always_comb begin
      err_code = ERR_NONE;
      if (!addr_in_range) begin
         err_code = ERR_OOR;
      end else if (req_write && lock_q && (addr_idx != ADDR_W'(NUM_REGS-1))) begin
         err_code = ERR_LOCK;
      end
   end

   // Decode the accepted, error-free bus write into one enable per register
   always_comb begin
      bus_we = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (accept && req_write && (err_code == ERR_NONE) && (addr_idx == ADDR_W'(i))) begin
            bus_we[i] = 1'b1;
         end
      end
   end

   // Read mux over the visible register values
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (addr_idx == ADDR_W'(i)) begin
            rd_word = reg_word[i];
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         mmr_byte_reg #(
            .DATA_W(DATA_W)
         ) u_reg (
            .clk       (clk),
            .rst       (rst),
            .bus_we    (bus_we[gi]),
            .bus_wstrb (req_wstrb),
            .bus_wdata (req_wdata),
            .hw_we     (hw_we[gi]),
            .hw_wdata  (hw_wdata[gi*DATA_W +: DATA_W]),
            .q         (reg_raw[gi])
         );
`ifdef MMR_BANK_LOCK_EN
         if (gi == NUM_REGS-1) begin : g_lock_view
            assign reg_word[gi] = {reg_raw[gi][DATA_W-1:LOCK_BIT+1], lock_q};
         end else begin : g_plain_view
            assign reg_word[gi] = reg_raw[gi];
         end
`else
         assign reg_word[gi] = reg_raw[gi];
`endif
         assign reg_q[gi*DATA_W +: DATA_W] = reg_word[gi];
      end
   endgenerate

`ifdef MMR_BANK_LOCK_EN
   // Sticky lock: set by a bus write of 1 to bit 0 of the last register, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_q <= 1'b0;
      end else if (bus_we[NUM_REGS-1] && req_wstrb[LOCK_BIT/8] && req_wdata[LOCK_BIT]) begin
         lock_q <= 1'b1;
      end
   end
`else
   assign lock_q = 1'b0;
`endif

   // Handshake FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and handshake outputs: ready in IDLE, response valid in RESP
   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_d = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Capture the response at the accept edge and hold it through backpressure
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else if (accept) begin
         rsp_rdata <= (!req_write && (err_code == ERR_NONE)) ? rd_word : '0;
         rsp_err   <= (err_code != ERR_NONE);
      end
   end

   // One-cycle write strobe following each successful bus write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_pulse <= '0;
      end else begin
         wr_pulse <= bus_we;
      end
   end

endmodule
